// File: rtl/config_report_tx.sv
// config_report_tx: serialises the live config registers to the host as a
// 5-byte UART 8N1 frame (A5, tagged mode, tagged brightness, tagged anim, xor chk).
// Frames go out on report_req, or on any config change when AUTO_REPORT is set.
module config_report_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter bit AUTO_REPORT  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       report_req,
  input  logic [3:0] mode,
  input  logic [3:0] brightness,
  input  logic [3:0] animation_sel,
  output logic       tx,
  output logic       busy,
  output logic       done
);
  localparam int BW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  // second-to-last baud tick; only meaningful when a bit spans 2+ cycles
  localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
  // reset values of the config block, so reset alone never sends a frame
  localparam logic [11:0] CFG_RST = 12'h0F0;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [2:0]    byte_idx;
  logic [3:0]    f_mode, f_bri, f_anim;
  logic [11:0]   last_sent;
  logic          pending;
  logic [7:0]    cur_byte;

  logic [11:0] cfg;
  logic        cfg_changed, trigger, baud_end, last_byte;
  logic [2:0]  nxt_bit;

  assign cfg         = {mode, brightness, animation_sel};
  assign cfg_changed = AUTO_REPORT && (cfg != last_sent);
  assign trigger     = report_req || pending || cfg_changed;
  assign baud_end    = (baud_cnt == BAUD_LAST);
  assign last_byte   = (byte_idx == 3'd4);
  assign nxt_bit     = bit_idx + 3'd1;

  // byte currently on the wire, built from the snapshotted values
  always_comb begin
    cur_byte = 8'hA5;
    case (byte_idx)
      3'd0:    cur_byte = 8'hA5;
      3'd1:    cur_byte = {4'h0, f_mode};
      3'd2:    cur_byte = {4'h1, f_bri};
      3'd3:    cur_byte = {4'h2, f_anim};
      default: cur_byte = {4'h0, f_mode} ^ {4'h1, f_bri} ^ {4'h2, f_anim};
    endcase
  end

  // frame sequencer: snapshot, start/data/stop per byte, pending-request capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      f_mode    <= '0;
      f_bri     <= '0;
      f_anim    <= '0;
      last_sent <= CFG_RST;
      pending   <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (trigger) begin
          f_mode    <= mode;
          f_bri     <= brightness;
          f_anim    <= animation_sel;
          last_sent <= cfg;
          pending   <= 1'b0;
          state     <= START;
          busy      <= 1'b1;
          tx        <= 1'b0;
          baud_cnt  <= '0;
          bit_idx   <= '0;
          byte_idx  <= '0;
        end
        START: if (baud_end) begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          state    <= DATA;
          tx       <= cur_byte[0];
        end else baud_cnt <= baud_cnt + 1'b1;
        DATA: if (baud_end) begin
          baud_cnt <= '0;
          if (bit_idx == 3'd7) begin
            state <= STOP;
            tx    <= 1'b1;
            // one-cycle stop bit: the next cycle is already the last of the frame
            if (CLKS_PER_BIT == 1 && last_byte) done <= 1'b1;
          end else begin
            bit_idx <= nxt_bit;
            tx      <= cur_byte[nxt_bit];
          end
        end else baud_cnt <= baud_cnt + 1'b1;
        STOP: if (baud_end) begin
          baud_cnt <= '0;
          if (last_byte) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            byte_idx <= byte_idx + 3'd1;
            state    <= START;
            tx       <= 1'b0;
          end
        end else begin
          baud_cnt <= baud_cnt + 1'b1;
          if (CLKS_PER_BIT > 1 && last_byte && baud_cnt == BAUD_PRE) done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
      // events during a frame collapse into one follow-up frame
      if (state != IDLE && (report_req || cfg_changed)) pending <= 1'b1;
    end
  end
endmodule
